// File: rtl/multicycle_alu.sv
// Registered ALU with start/done handshake: single-cycle ADD/ADC/NAND/SUB and,
// when ALU_MUL_EN is defined, an unsigned shift-add multiply taking WIDTH cycles.
module multicycle_alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             illegal
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADC  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;

  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry;
  logic             r_done;
  logic             r_illegal;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_adc;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH-1:0] w_res;
  logic             w_cy;
  logic             w_legal;
  logic             w_is_mul;

  assign w_add = {1'b0, a} + {1'b0, b};
  assign w_adc = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
  // Bit WIDTH of the widened difference is the unsigned borrow.
  assign w_sub = {1'b0, a} - {1'b0, b};

  always_comb begin
    w_res   = r_result;
    w_cy    = r_carry;
    w_legal = 1'b1;
    case (op)
      OP_ADD:  {w_cy, w_res} = w_add;
      OP_ADC:  {w_cy, w_res} = w_adc;
      OP_NAND: w_res = ~(a & b);
      OP_SUB:  {w_cy, w_res} = w_sub;
      default: w_legal = 1'b0;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [2:0]        OP_MUL   = 3'b100;
  localparam int unsigned       CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]     CNT_LAST = CW'(WIDTH - 1);
  localparam logic [0:0]        ST_IDLE  = 1'b0;
  localparam logic [0:0]        ST_MUL   = 1'b1;

  logic [0:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_is_mul   = (op == OP_MUL);
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign busy       = (r_state == ST_MUL);
`else
  assign w_is_mul = 1'b0;
  assign busy     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_carry   <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
`ifdef ALU_MUL_EN
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef ALU_MUL_EN
      if (r_state == ST_MUL) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CW'(1);
        if (r_cnt == CNT_LAST) begin
          r_result  <= w_acc_next[WIDTH-1:0];
          r_carry   <= |w_acc_next[2*WIDTH-1:WIDTH];
          r_zero    <= (w_acc_next[WIDTH-1:0] == '0);
          r_done    <= 1'b1;
          r_illegal <= 1'b0;
          r_state   <= ST_IDLE;
        end
      end else
`endif
      if (start) begin
`ifdef ALU_MUL_EN
        if (w_is_mul) begin
          r_state  <= ST_MUL;
          r_cnt    <= '0;
          r_acc    <= '0;
          r_mcand  <= {{WIDTH{1'b0}}, a};
          r_mplier <= b;
        end else
`endif
        begin
          r_done    <= 1'b1;
          r_illegal <= ~w_legal;
          if (w_legal && !w_is_mul) begin
            r_result <= w_res;
            r_carry  <= w_cy;
            r_zero   <= (w_res == '0);
          end
        end
      end
    end
  end

  assign result  = r_result;
  assign zero    = r_zero;
  assign carry   = r_carry;
  assign done    = r_done;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu: arithmetic reference model compared every cycle,
// plus directed vectors with literal expectations.
module tb_multicycle_alu;

  localparam int unsigned W = 16;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         carry_in;
  logic         busy, done, zero, carry, illegal;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .carry    (carry),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic, a pending multiply is a countdown.
  function automatic logic [W:0] ref_op(input logic [2:0] o, input logic [W-1:0] x, y,
                                        input logic ci, input logic old_c);
    logic [W:0] r;
    case (o)
      3'd0:    r = x + y;
      3'd1:    r = x + y + ci;
      3'd2:    r = {old_c, ~(x & y)};
      default: r = (x < y) ? {1'b1, x - y} : {1'b0, x - y};
    endcase
    return r;
  endfunction

  logic [W-1:0]   m_result;
  logic           m_zero, m_carry, m_done, m_illegal;
  int             m_left;
  logic [2*W-1:0] m_prod;
  logic [W:0]     m_tmp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_result <= '0; m_zero <= 0; m_carry <= 0; m_done <= 0; m_illegal <= 0;
      m_left <= 0; m_prod <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_result  <= m_prod[W-1:0];
          m_carry   <= (m_prod[2*W-1:W] != 0);
          m_zero    <= (m_prod[W-1:0] == 0);
          m_done    <= 1'b1;
          m_illegal <= 1'b0;
        end
      end else if (start) begin
        if (MUL_EN && op == 3'd4) begin
          m_left <= W;
          m_prod <= (2*W)'(a) * (2*W)'(b);
        end else if (op > 3'd3) begin
          m_done    <= 1'b1;
          m_illegal <= 1'b1;
        end else begin
          m_tmp      = ref_op(op, a, b, carry_in, m_carry);
          m_result  <= m_tmp[W-1:0];
          m_carry   <= m_tmp[W];
          m_zero    <= (m_tmp[W-1:0] == 0);
          m_done    <= 1'b1;
          m_illegal <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_result",  result,  m_result);
      check("cyc_zero",    zero,    m_zero);
      check("cyc_carry",   carry,   m_carry);
      check("cyc_done",    done,    m_done);
      check("cyc_illegal", illegal, m_illegal);
      check("cyc_busy",    busy,    (m_left > 0));
    end
  end

  // Drives one start cycle; returns #1 after the sampling edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, y, input logic ci);
    op = o; a = x; b = y; carry_in = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [W-1:0] r, input logic z, c, d, il);
    check({name, "_result"},  result,  r);
    check({name, "_zero"},    zero,    z);
    check({name, "_carry"},   carry,   c);
    check({name, "_done"},    done,    d);
    check({name, "_illegal"}, illegal, il);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; carry_in = 1'b0;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    expect_out("reset", 16'h0000, 0, 0, 0, 0);
    check("reset_busy", busy, 0);

    issue(3'd0, 16'hFFFF, 16'h0001, 1'b0);
    expect_out("add_wrap", 16'h0000, 1, 1, 1, 0);
    issue(3'd1, 16'h7FFF, 16'h0000, 1'b1);
    expect_out("adc", 16'h8000, 0, 0, 1, 0);
    issue(3'd2, 16'hFFFF, 16'hFFFF, 1'b0);
    expect_out("nand", 16'h0000, 1, 0, 1, 0);
    issue(3'd3, 16'd3, 16'd5, 1'b0);
    expect_out("sub_borrow", 16'hFFFE, 0, 1, 1, 0);
    issue(3'd3, 16'd5, 16'd5, 1'b0);
    expect_out("sub_eq", 16'h0000, 1, 0, 1, 0);
    issue(3'd6, 16'd1, 16'd1, 1'b1);
    expect_out("illegal_110", 16'h0000, 1, 0, 1, 1);
    @(posedge clk); #1;
    expect_out("illegal_hold", 16'h0000, 1, 0, 0, 1);

    // NAND must leave a set carry alone.
    issue(3'd0, 16'hFFFF, 16'h0001, 1'b0);
    issue(3'd2, 16'hF0F0, 16'h0FF0, 1'b0);
    expect_out("nand_keep_c", 16'hFF0F, 0, 1, 1, 0);

    // Back-to-back starts keep done high.
    issue(3'd0, 16'd1, 16'd2, 1'b0);
    expect_out("b2b_1", 16'd3, 0, 0, 1, 0);
    issue(3'd0, 16'd3, 16'd4, 1'b0);
    expect_out("b2b_2", 16'd7, 0, 0, 1, 0);
    @(posedge clk); #1;

`ifdef ALU_MUL_EN
    issue(3'd4, 16'h0100, 16'h0100, 1'b0);
    dones = 0;
    for (int k = 1; k <= W; k++) begin
      if (k < W) begin
        check("mul_busy", busy, 1);
        check("mul_nodone", done, 0);
      end
      if (k == 4) begin
        op = 3'd0; a = 16'd1; b = 16'd1; start = 1'b1;
      end
      if (done) dones++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    expect_out("mul_big", 16'h0000, 1, 1, 1, 0);
    check("mul_big_busy", busy, 0);
    dones++;
    @(posedge clk); #1;
    if (done) dones++;
    check("mul_one_done", dones, 1);

    issue(3'd4, 16'd7, 16'd6, 1'b0);
    op = 3'd7; a = 16'hFFFF; b = 16'hFFFF;
    repeat (W - 1) @(posedge clk);
    #1;
    check("mul_small_pre", done, 0);
    @(posedge clk); #1;
    expect_out("mul_small", 16'h002A, 0, 0, 1, 0);

    // Abort a multiply with reset on its fifth cycle.
    issue(3'd4, 16'd3, 16'd5, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
`else
    issue(3'd4, 16'd7, 16'd6, 1'b0);
    expect_out("mul_off", 16'd7, 0, 0, 1, 1);
    check("mul_off_busy", busy, 0);
    issue(3'd0, 16'h1234, 16'h1111, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
`endif
    #1;
    expect_out("async_rst", 16'h0000, 0, 0, 0, 0);
    check("async_rst_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("no_done_after_abort", dones, 0);
    issue(3'd0, 16'd2, 16'd3, 1'b0);
    expect_out("post_rst_add", 16'd5, 0, 0, 1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
